// File: rtl/perceptron_ctrl.sv
// Host command sequencer: parses framed UART bytes, loads operands, launches datapath ops, streams results.
// Optional inter-byte timeout abort enabled by defining PERCEPTRON_CTRL_TIMEOUT_EN.
module perceptron_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic              op_start,
  output logic [1:0]        op_sel,
  input  logic              op_done,
  input  logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              err,
  output logic              ovr
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_EXEC, S_SEND} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nxt;
  logic [DATA_W-1:0]  shadow_q, shadow_d;
  logic               dst_b_q, dst_b_d;
  logic [DATA_W-1:0]  reg_a_q, reg_a_d, reg_b_q, reg_b_d;
  logic [DATA_W-1:0]  snap_q, snap_d;
  logic               op_start_q, op_start_d;
  logic [1:0]         op_sel_q, op_sel_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               ovr_q, ovr_d;

`ifdef PERCEPTRON_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo_c;
  assign unused_tmo_c = (TIMEOUT_CYC == 0);
`endif

  assign cnt_nxt = cnt_q + CNT_W'(1);

  // Frame parser / sequencer next-state and output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    dst_b_d    = dst_b_q;
    reg_a_d    = reg_a_q;
    reg_b_d    = reg_b_q;
    snap_d     = snap_q;
    op_start_d = 1'b0;
    op_sel_d   = op_sel_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    err_d      = err_q;
    ovr_d      = ovr_q;
`ifdef PERCEPTRON_CTRL_TIMEOUT_EN
    tmo_d      = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == 8'h00) state_d = S_HDR;
      end
      S_HDR: begin
        if (rx_valid) begin
          cnt_d = '0;
          case (rx_data)
            8'h00, 8'h01: begin
              state_d  = S_LOAD;
              dst_b_d  = rx_data[0];
              shadow_d = '0;
            end
            8'h02: begin
              state_d = S_SEND;
              snap_d  = result;
            end
            8'h03, 8'h05, 8'h06: begin
              state_d    = S_EXEC;
              op_start_d = 1'b1;
              op_sel_d   = (rx_data == 8'h03) ? 2'd0 : (rx_data == 8'h05) ? 2'd1 : 2'd2;
            end
            default: begin
              state_d = S_IDLE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_LOAD: begin
        if (rx_valid) begin
          shadow_d[{cnt_q, 3'b000} +: 8] = rx_data;
          if (cnt_q == CNT_W'(NBYTES - 1)) begin
            if (dst_b_q) reg_b_d = shadow_d;
            else         reg_a_d = shadow_d;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_nxt;
          end
        end
      end
      S_EXEC: begin
        if (rx_valid) ovr_d = 1'b1;
        // A done coincident with our own start pulse belongs to no op of ours
        if (op_done && !op_start_q) state_d = S_IDLE;
      end
      S_SEND: begin
        if (rx_valid) ovr_d = 1'b1;
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = snap_q[{cnt_q, 3'b000} +: 8];
        end else if (tx_ready) begin
          if (cnt_q == CNT_W'(NBYTES - 1)) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
            cnt_d      = '0;
          end else begin
            cnt_d     = cnt_nxt;
            tx_data_d = snap_q[{cnt_nxt, 3'b000} +: 8];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef PERCEPTRON_CTRL_TIMEOUT_EN
    // Abort a stalled frame; loaded registers keep their previous values
    if ((state_q == S_HDR || state_q == S_LOAD) && !rx_valid) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        state_d  = S_IDLE;
        err_d    = 1'b1;
        cnt_d    = '0;
        shadow_d = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
`endif

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shadow_q   <= '0;
      dst_b_q    <= 1'b0;
      reg_a_q    <= '0;
      reg_b_q    <= '0;
      snap_q     <= '0;
      op_start_q <= 1'b0;
      op_sel_q   <= 2'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      dst_b_q    <= dst_b_d;
      reg_a_q    <= reg_a_d;
      reg_b_q    <= reg_b_d;
      snap_q     <= snap_d;
      op_start_q <= op_start_d;
      op_sel_q   <= op_sel_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef PERCEPTRON_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign reg_a    = reg_a_q;
  assign reg_b    = reg_b_q;
  assign op_start = op_start_q;
  assign op_sel   = op_sel_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign ovr      = ovr_q;

endmodule

// File: tb/tb_perceptron_ctrl.sv
// Directed self-checking bench for perceptron_ctrl with a small datapath model.
module tb_perceptron_ctrl;

  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              nRst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] reg_a, reg_b, result;
  logic              op_start;
  logic [1:0]        op_sel;
  logic              op_done;
  logic              busy, err, ovr;

  int n_cmp = 0;
  int n_bad = 0;

  logic       md_en;
  logic       man_done;
  logic [1:0] dly;
  int         start_cnt = 0;
  logic [1:0] last_sel;

  perceptron_ctrl #(.DATA_W(DATA_W), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .nRst(nRst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .reg_a(reg_a), .reg_b(reg_b), .op_start(op_start), .op_sel(op_sel),
    .op_done(op_done), .result(result), .busy(busy), .err(err), .ovr(ovr)
  );

  always #5 clk = ~clk;

  // Datapath model: done three cycles after the start pulse
  always @(posedge clk or negedge nRst) begin
    if (!nRst)                  dly <= 2'd0;
    else if (op_start && md_en) dly <= 2'd3;
    else if (dly != 2'd0)       dly <= dly - 2'd1;
  end
  assign op_done = (dly == 2'd1) | man_done;

  always @(posedge clk) begin
    if (op_start) begin
      start_cnt <= start_cnt + 1;
      last_sel  <= op_sel;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Caller is at a negedge; byte is accepted by the following posedge
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    nRst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    md_en = 1'b1; man_done = 1'b0; result = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({reg_a, reg_b, tx_data, tx_valid, op_start, op_sel} !== 82'd0) begin
      n_bad++; $display("FAIL reset_data: got %h/%h/%h/%b/%b/%0d required all zero",
                        reg_a, reg_b, tx_data, tx_valid, op_start, op_sel);
    end
    n_cmp++;
    if ({busy, err, ovr} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: busy/err/ovr got %b required 000", {busy, err, ovr});
    end
    nRst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_a();
    int s0;
    logic [7:0] fr [6];
    fr = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) send_byte(fr[i]);
    n_cmp++;
    if (reg_a !== 32'h0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL load_a_partial: reg_a=%h busy=%b required 0/1", reg_a, busy);
    end
    send_byte(fr[5]);
    n_cmp++;
    if (reg_a !== 32'h0000_0001) begin
      n_bad++; $display("FAIL load_a_value: got %h required 00000001", reg_a);
    end
    n_cmp++;
    if (reg_b !== 32'h0 || busy !== 1'b0 || start_cnt != s0) begin
      n_bad++; $display("FAIL load_a_side: reg_b=%h busy=%b starts=%0d required 0/0/0",
                        reg_b, busy, start_cnt - s0);
    end
  endtask

  task automatic test_mul();
    int s0, wait_cyc;
    logic [7:0] fr [6];
    fr = '{8'h00, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 6; i++) send_byte(fr[i]);
    n_cmp++;
    if (reg_b !== 32'h0000_0003 || reg_a !== 32'h0000_0001) begin
      n_bad++; $display("FAIL load_b: reg_b=%h reg_a=%h required 00000003/00000001", reg_b, reg_a);
    end
    s0 = start_cnt;
    send_byte(8'h00);
    send_byte(8'h05);
    n_cmp++;
    if (op_start !== 1'b1 || op_sel !== 2'd1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL mul_start: op_start=%b op_sel=%0d busy=%b required 1/1/1",
                        op_start, op_sel, busy);
    end
    wait_cyc = 0;
    while (op_done !== 1'b1 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
      if (op_start !== 1'b0) begin
        n_cmp++; n_bad++; $display("FAIL mul_pulse_width: op_start still high after %0d cycles", wait_cyc);
      end
    end
    n_cmp++;
    if (wait_cyc != 3 || busy !== 1'b1) begin
      n_bad++; $display("FAIL mul_done_wait: cycles=%0d busy=%b required 3/1", wait_cyc, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || start_cnt - s0 != 1 || last_sel !== 2'd1) begin
      n_bad++; $display("FAIL mul_end: busy=%b starts=%0d sel=%0d required 0/1/1",
                        busy, start_cnt - s0, last_sel);
    end
  endtask

  task automatic test_send();
    logic [7:0] held;
    logic [7:0] exp [4];
    logic [7:0] got [$];
    logic       stalled;
    int         extra;
    exp = '{8'h78, 8'h56, 8'h34, 8'h12};
    result = 32'h1234_5678; tx_ready = 1'b0;
    send_byte(8'h00);
    send_byte(8'h02);
    result = 32'hDEAD_BEEF;
    stalled = 1'b0; held = 8'h00;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      if (tx_valid && stalled) begin
        n_cmp++;
        if (tx_data !== held) begin
          n_bad++; $display("FAIL send_stable: tx_data=%h required %h", tx_data, held);
        end
      end
      tx_ready = ~tx_ready;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      stalled = tx_valid && !tx_ready;
      held = tx_data;
      @(negedge clk);
    end
    n_cmp++;
    if (got.size() != 4) begin
      n_bad++; $display("FAIL send_count: got %0d bytes required 4", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        n_bad++; $display("FAIL send_byte%0d: got %h required %h", i,
                          (i < got.size()) ? got[i] : 8'hxx, exp[i]);
      end
    end
    n_cmp++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL send_end: tx_valid=%b busy=%b required 0/0", tx_valid, busy);
    end
    tx_ready = 1'b1; extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (tx_valid) extra++;
    end
    tx_ready = 1'b0;
    n_cmp++;
    if (extra != 0) begin
      n_bad++; $display("FAIL send_extra: %0d extra valid cycles required 0", extra);
    end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] fr [4];
    fr = '{8'h07, 8'h09, 8'h00, 8'h09};
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL err_pre: got %b required 0", err);
    end
    for (int i = 0; i < 2; i++) begin
      send_byte(fr[i]);
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++; $display("FAIL idle_discard%0d: busy=%b required 0", i, busy);
      end
    end
    send_byte(fr[2]);
    send_byte(fr[3]);
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0 || reg_a !== 32'h1 || reg_b !== 32'h3) begin
      n_bad++; $display("FAIL bad_opcode: err=%b busy=%b reg_a=%h reg_b=%h required 1/0/1/3",
                        err, busy, reg_a, reg_b);
    end
  endtask

  task automatic test_exec_ovr();
    md_en = 1'b0;
    send_byte(8'h00);
    rx_valid = 1'b1; rx_data = 8'h03; man_done = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    man_done = 1'b1;
    n_cmp++;
    if (op_start !== 1'b1 || op_sel !== 2'd0 || ovr !== 1'b0) begin
      n_bad++; $display("FAIL clear_start: op_start=%b op_sel=%0d ovr=%b required 1/0/0",
                        op_start, op_sel, ovr);
    end
    @(negedge clk);
    man_done = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL early_done: busy=%b required 1 (done during start ignored)", busy);
    end
    send_byte(8'h00);
    n_cmp++;
    if (ovr !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL exec_ovr: ovr=%b busy=%b required 1/1", ovr, busy);
    end
    rx_valid = 1'b1; rx_data = 8'h00; man_done = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; man_done = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || ovr !== 1'b1 || op_sel !== 2'd0) begin
      n_bad++; $display("FAIL done_with_rx: busy=%b ovr=%b op_sel=%0d required 0/1/0", busy, ovr, op_sel);
    end
    send_byte(8'h05);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL dropped_byte_state: busy=%b required 0", busy);
    end
    md_en = 1'b1;
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] fr [6];
    fr = '{8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'hAA);
    #2 nRst = 1'b0;
    #1;
    n_cmp++;
    if ({reg_a, reg_b, tx_data, tx_valid, op_start, op_sel, busy, err, ovr} !== 85'd0) begin
      n_bad++; $display("FAIL reset_mid: reg_a=%h reg_b=%h busy=%b err=%b ovr=%b required all zero",
                        reg_a, reg_b, busy, err, ovr);
    end
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) send_byte(fr[i]);
    n_cmp++;
    if (reg_a !== 32'h0000_0005 || busy !== 1'b0) begin
      n_bad++; $display("FAIL load_after_reset: reg_a=%h busy=%b required 00000005/0", reg_a, busy);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] fr [6];
    fr = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'hAA);
    repeat (101) @(negedge clk);
`ifdef PERCEPTRON_CTRL_TIMEOUT_EN
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0 || reg_a !== 32'h5) begin
      n_bad++; $display("FAIL timeout_abort: err=%b busy=%b reg_a=%h required 1/0/00000005", err, busy, reg_a);
    end
    for (int i = 0; i < 6; i++) send_byte(fr[i]);
    n_cmp++;
    if (reg_a !== 32'h0000_0004 || busy !== 1'b0) begin
      n_bad++; $display("FAIL timeout_reload: reg_a=%h busy=%b required 00000004/0", reg_a, busy);
    end
`else
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b1 || reg_a !== 32'h5) begin
      n_bad++; $display("FAIL no_timeout: err=%b busy=%b reg_a=%h required 0/1/00000005", err, busy, reg_a);
    end
    for (int i = 3; i < 6; i++) send_byte(fr[i]);
    n_cmp++;
    if (reg_a !== 32'h0000_00AA || busy !== 1'b0) begin
      n_bad++; $display("FAIL late_complete: reg_a=%h busy=%b required 000000aa/0", reg_a, busy);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_a();
    test_mul();
    test_send();
    test_bad_opcode();
    test_exec_ovr();
    test_reset_mid_load();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/perceptron_ctrl.md
Name: perceptron_ctrl

Overview:
Host command sequencer for the perceptron datapath. Parses framed command bytes from the UART receiver, assembles operand words, and sequences the multiply / multiply-accumulate unit with a start/done handshake. Streams the result word back to the UART transmitter on request. Sits between uart_rx/uart_tx and the MAC core inside perceptron.

Parameters:
DATA_W, 32, operand/result width in bits; must be a multiple of 8
NBYTES, DATA_W/8, bytes per operand/result word (derived, not overridable)
TIMEOUT_CYC, 2000000, inter-byte timeout in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
nRst  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready
reg_a  out  DATA_W  operand A to datapath
reg_b  out  DATA_W  operand B to datapath
op_start  out  1  one-cycle pulse launching a datapath op
op_sel  out  2  0=CLEAR acc, 1=MUL, 2=MUL_ADD; stable from op_start until op_done
op_done  in  1  one-cycle strobe from datapath; ignored outside EXEC
result  in  DATA_W  datapath result/accumulator
busy  out  1  high whenever state != IDLE
err  out  1  sticky: bad opcode or timeout abort
ovr  out  1  sticky: byte received while in EXEC or SEND

Behaviour:
- Reset (async, nRst low): state IDLE; reg_a, reg_b, tx_data = 0; tx_valid, op_start, busy, err, ovr = 0; op_sel = 0; byte counter = 0.
- Frame format: header 0x00, opcode byte, then NBYTES operand bytes, LSB first, for loads only.
- Opcodes: 0x00 LOAD_A, 0x01 LOAD_B, 0x02 OUT_RES, 0x03 CLEAR, 0x05 MUL, 0x06 MUL_ADD. Any other opcode sets err and returns to IDLE.
- IDLE: byte 0x00 -> HDR. Non-zero bytes are discarded silently.
- HDR: next byte is the opcode.
  - LOAD_A / LOAD_B -> LOAD, counter=0.
  - OUT_RES -> SEND.
  - CLEAR / MUL / MUL_ADD -> EXEC.
- LOAD: each byte is written into a shadow register at position counter*8; counter increments.
  - On byte NBYTES, the shadow is copied to reg_a or reg_b in the same clock edge; -> IDLE.
  - reg_a and reg_b never show partial words.
- EXEC:
  - op_start is high exactly in the first cycle after the opcode byte is accepted (opcode at edge N -> op_start high cycle N+1).
  - Wait for op_done; a done in the op_start cycle is ignored.
  - On op_done -> IDLE; busy falls the following cycle.
- SEND:
  - On entry, result is snapshotted.
  - tx_valid rises the cycle after entry, with tx_data = byte 0.
  - On each tx_valid && tx_ready the next byte is presented the next cycle, with no gap.
  - After byte NBYTES-1 is accepted, tx_valid falls and state -> IDLE.
  - tx_data is stable while tx_valid && !tx_ready.
- rx_valid in EXEC or SEND: byte dropped, ovr set; state unaffected.
- Simultaneous rx_valid and op_done in EXEC: op_done honoured, byte dropped, ovr set.
- err/ovr clear only on reset.
- Reset mid-frame: partial shadow data is discarded and reg_a/reg_b clear to 0.

Optional Feature:
PERCEPTRON_CTRL_TIMEOUT_EN
- Defined: a counter reloads on every accepted byte while in HDR or LOAD.
  - If TIMEOUT_CYC cycles elapse without a byte, the frame is aborted: -> IDLE, err set, shadow discarded, reg_a/reg_b unchanged.
  - The counter is inactive in IDLE, EXEC and SEND.
- Undefined: no timeout logic; a partial frame waits indefinitely.

Test Plan:
- Send 00 00 01 00 00 00 -> reg_a=0x00000001 after the 6th byte, reg_b=0, busy low, no op_start pulse.
- Send 00 01 03 00 00 00 then 00 05; model returns op_done 3 cycles after op_start -> reg_b=0x00000003, exactly one op_start pulse with op_sel=1, busy low the cycle after op_done.
- result=0x12345678, send 00 02 with tx_ready toggling every other cycle -> tx bytes 78,56,34,12 each accepted exactly once, tx_data stable while stalled, tx_valid low after byte 4.
- Send 07 09 00 09 -> 07 and 09 discarded in IDLE; opcode 09 sets err; reg_a/reg_b unchanged; busy low.
- During EXEC, pulse rx_valid with 0x00 -> ovr=1, state still EXEC; then assert nRst low mid-LOAD (after 00 00 AA) -> all outputs return to reset values immediately.
- With PERCEPTRON_CTRL_TIMEOUT_EN and TIMEOUT_CYC=100: send 00 00 AA, idle 101 cycles -> err=1, state IDLE, reg_a unchanged; the following frame 00 00 04 00 00 00 loads reg_a=0x00000004.
